// File: rtl/down_counter_pkg.sv
// Shared types for the down-counter timer.
//
// dc_state_t : controller state, IDLE (waiting for load/start) or RUN (counting down).
package down_counter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dc_state_t;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable, start/stop-controlled down-counter with a one-cycle terminal-count pulse.
// Intended as a timeout/delay timer: load a count, start it, get `done` when it hits zero.
//
// Parameters
//   WIDTH       counter width in bits
// Ports
//   clock       in   single clock, all state updates on its rising edge
//   reset_n     in   asynchronous active-low reset
//   enable      in   count-enable, decrements only while running
//   load        in   capture load_value into count_out and the reload register (IDLE only)
//   load_value  in   WIDTH-bit value captured by load
//   start       in   begin countdown from the current (or just-loaded) count (IDLE only)
//   stop        in   abort countdown, count is held (RUN only)
//   count_out   out  current counter value
//   busy        out  high while running
//   done        out  registered one-cycle pulse on terminal count
//
// Build option
//   DOWN_COUNTER_AUTO_RELOAD_EN : when defined, reaching terminal count reloads the counter
//   from the reload register and keeps running, giving a periodic done until stop.
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done
);

    dc_state_t        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    // Count that a start in this cycle would run from: a same-cycle load takes effect first.
    logic [WIDTH-1:0] start_count;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        done_d      = 1'b0;
        start_count = count_q;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    count_d     = load_value;
                    reload_d    = load_value;
                    start_count = load_value;
                end
                if (start) begin
                    // Starting from zero is already terminal: pulse done, never enter RUN.
                    if (start_count != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                // stop has priority over a terminal decrement; zero is never decremented.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (enable && (count_q != '0)) begin
                    if (count_q == WIDTH'(1)) begin
                        done_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                        count_d = reload_q;
`else
                        count_d = '0;
                        state_d = ST_IDLE;
`endif
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign count_out = count_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: a vector table, hand-written corner sequences
// (async reset mid-run, auto-reload when built with DOWN_COUNTER_AUTO_RELOAD_EN) and a
// randomized phase against a behavioural model.
module tb_down_counter_timer;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       load;
    logic [3:0] load_value;
    logic       start;
    logic       stop;
    logic [3:0] count_out;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    down_counter_timer #(.WIDTH(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .count_out  (count_out),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       st;
        logic       sp;
        logic       en;
        logic [3:0] ec;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int ec, input int eb, input int ed);
        check({tag, ".count"}, int'(count_out), ec);
        check({tag, ".busy"}, int'(busy), eb);
        check({tag, ".done"}, int'(done), ed);
    endtask

    task automatic drive(input logic ld, input logic [3:0] lv, input logic st,
                         input logic sp, input logic en);
        load       = ld;
        load_value = lv;
        start      = st;
        stop       = sp;
        enable     = en;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic add(input logic ld, input logic [3:0] lv, input logic st, input logic sp,
                       input logic en, input int ec, input int eb, input int ed);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.en = en;
        v.ec = 4'(ec); v.eb = eb[0]; v.ed = ed[0];
        vecs.push_back(v);
    endtask

    // Behavioural model state
    int  m_count;
    int  m_reload;
    bit  m_run;
    bit  m_done;

    initial begin
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;

        // ld lv st sp en | count busy done (state after the edge)
        add(1, 3, 0, 0, 0,  3, 0, 0);                   // load 3
        add(0, 0, 1, 0, 1,  3, 1, 0);                   // start: E0, busy after E0
        add(0, 0, 0, 0, 1,  2, 1, 0);
        add(0, 0, 0, 0, 1,  1, 1, 0);
        add(0, 0, 0, 0, 1,  AR ? 3 : 0, AR, 1);         // E0+3: terminal
        add(0, 0, 0, 1, 0,  AR ? 3 : 0, 0, 0);          // stop (only matters with reload)
        add(1, 0, 1, 0, 0,  0, 0, 1);                   // load 0 + start: no RUN, done
        add(0, 0, 0, 0, 0,  0, 0, 0);
        add(1, 6, 0, 0, 0,  6, 0, 0);
        add(0, 0, 1, 0, 1,  6, 1, 0);
        add(0, 0, 0, 0, 1,  5, 1, 0);
        add(0, 0, 0, 0, 1,  4, 1, 0);
        add(0, 0, 0, 0, 1,  3, 1, 0);
        add(0, 0, 0, 0, 1,  2, 1, 0);
        add(1, 9, 1, 0, 0,  2, 1, 0);                   // load/start ignored in RUN
        add(0, 0, 0, 1, 1,  2, 0, 0);                   // stop at 2: held, no done
        add(0, 0, 0, 0, 0,  2, 0, 0);
        add(1, 4, 0, 0, 0,  4, 0, 0);
        add(0, 0, 1, 0, 0,  4, 1, 0);
        add(0, 0, 0, 0, 1,  3, 1, 0);                   // enable 1,0,1,1,0,1
        add(0, 0, 0, 0, 0,  3, 1, 0);
        add(0, 0, 0, 0, 1,  2, 1, 0);
        add(0, 0, 0, 0, 1,  1, 1, 0);
        add(0, 0, 0, 0, 0,  1, 1, 0);
        add(0, 0, 0, 0, 1,  AR ? 4 : 0, AR, 1);
        add(0, 0, 0, 1, 0,  AR ? 4 : 0, 0, 0);
        add(1, 1, 0, 0, 0,  1, 0, 0);
        add(0, 0, 1, 0, 0,  1, 1, 0);
        add(0, 0, 0, 1, 1,  1, 0, 0);                   // stop beats terminal decrement
        add(1, 15, 1, 0, 1, 15, 1, 0);                  // load+start from max value

        #12;
        check_all("reset", 0, 0, 0);
        reset_n = 1'b1;
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].en);
            step();
            check_all($sformatf("vec%0d", i), int'(vecs[i].ec), int'(vecs[i].eb),
                      int'(vecs[i].ed));
        end

        // Async reset mid-RUN at count 5: takes effect without a clock edge.
        do_reset();
        drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        step();
        check_all("rst_pre", 5, 1, 0);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("rst_async", 0, 0, 0);
        step();
        check_all("rst_held", 0, 0, 0);
        #3;
        reset_n = 1'b1;
        step();
        check_all("rst_after", 0, 0, 0);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        // Periodic done every 2 enabled cycles, busy stays high.
        do_reset();
        drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        step();
        check_all("ar_e0", 2, 1, 0);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            step();
            check_all($sformatf("ar_e%0d", k), (k % 2 == 0) ? 2 : 1, 1,
                      (k % 2 == 0) ? 1 : 0);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        check_all("ar_stop", 1, 0, 0);
`endif

        // Randomized phase against a behavioural model.
        do_reset();
        m_count  = 0;
        m_reload = 0;
        m_run    = 1'b0;
        m_done   = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic       r_ld, r_st, r_sp, r_en;
            logic [3:0] r_lv;
            r_ld = ($urandom_range(0, 3) == 0);
            r_lv = 4'($urandom_range(0, 15));
            r_st = ($urandom_range(0, 3) == 0);
            r_sp = ($urandom_range(0, 15) == 0);
            r_en = ($urandom_range(0, 3) != 0);
            drive(r_ld, r_lv, r_st, r_sp, r_en);

            m_done = 1'b0;
            if (!m_run) begin
                if (r_ld) begin
                    m_count  = int'(r_lv);
                    m_reload = int'(r_lv);
                end
                if (r_st) begin
                    if (m_count > 0) m_run = 1'b1;
                    else m_done = 1'b1;
                end
            end else if (r_sp) begin
                m_run = 1'b0;
            end else if (r_en && m_count > 0) begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    m_done = 1'b1;
                    if (AR) m_count = m_reload;
                    else m_run = 1'b0;
                end
            end

            step();
            check_all($sformatf("rnd%0d", c), m_count, int'(m_run), int'(m_done));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
